// File: rtl/accel_poll_sequencer.sv
// ADXL345 poll sequencer: one-time config write, then periodic 6-byte burst reads of X/Y/Z.
// Drives a byte-level I2C command engine with a single outstanding command.
module accel_poll_sequencer #(
  parameter logic [6:0]  DEV_ADDR       = 7'h1D,
  parameter int unsigned POLL_CYCLES    = 5000000,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic        clk_clk,
  input  logic        reset_reset,
  input  logic        enable,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic        cmd_start,
  output logic        cmd_stop,
  output logic        cmd_write,
  output logic        cmd_read,
  output logic        cmd_nack,
  output logic [7:0]  cmd_wdata,
  input  logic        done_valid,
  input  logic [7:0]  done_rdata,
  input  logic        done_nack,
  output logic [15:0] accel_x,
  output logic [15:0] accel_y,
  output logic [15:0] accel_z,
  output logic        sample_valid,
  output logic        busy,
  output logic        init_done,
  output logic [7:0]  err_cnt
);

  typedef enum logic [3:0] {
    StInitA, StInitR, StInitD, StIdle, StRdA, StRdR, StRdA2, StRdB, StPublish, StAbort
  } state_e;

  // PhLoad only follows reset, so the first command is raised one cycle after release.
  typedef enum logic [1:0] {PhLoad, PhIssue, PhWait} phase_e;

  typedef struct packed {
    logic       start;
    logic       stop;
    logic       write;
    logic       read;
    logic       nack;
    logic [7:0] wdata;
  } cmd_t;

  function automatic cmd_t cmd_for(state_e st, logic [2:0] idx);
    cmd_t c;
    c = '0;
    case (st)
      StInitA, StRdA: begin c.start = 1'b1; c.write = 1'b1; c.wdata = {DEV_ADDR, 1'b0}; end
      StInitR:        begin c.write = 1'b1; c.wdata = 8'h2D; end
      StInitD:        begin c.write = 1'b1; c.stop = 1'b1; c.wdata = 8'h08; end
      StRdR:          begin c.write = 1'b1; c.wdata = 8'h32; end
      StRdA2:         begin c.start = 1'b1; c.write = 1'b1; c.wdata = {DEV_ADDR, 1'b1}; end
      StRdB: begin
        c.read = 1'b1;
        c.nack = (idx == 3'd5);
        c.stop = (idx == 3'd5);
      end
      StAbort:        c.stop = 1'b1;
      default:        c = '0;
    endcase
    return c;
  endfunction

  state_e      state_q;
  phase_e      phase_q;
  cmd_t        cmd_q;
  logic        cmd_valid_q;
  logic [2:0]  idx_q;
  logic [31:0] poll_cnt_q;
  logic [31:0] tcnt_q;
  logic [7:0]  buf_q [6];
  logic [15:0] accel_x_q, accel_y_q, accel_z_q;
  logic        sample_valid_q;
  logic        init_done_q;
  logic [7:0]  err_cnt_q;

  state_e      adv_state;
  logic [2:0]  adv_idx;
  cmd_t        adv_cmd;
  logic        adv_issues;
  logic        timeout;
  logic        nack_fail;
  logic        fail;

  // Successor on a clean completion of the current command.
  always_comb begin
    adv_state = state_q;
    adv_idx   = idx_q;
    case (state_q)
      StInitA: adv_state = StInitR;
      StInitR: adv_state = StInitD;
      StInitD: adv_state = StIdle;
      StRdA:   adv_state = StRdR;
      StRdR:   adv_state = StRdA2;
      StRdA2: begin
        adv_state = StRdB;
        adv_idx   = 3'd0;
      end
      StRdB: begin
        if (idx_q == 3'd5) adv_state = StPublish;
        else               adv_idx   = idx_q + 3'd1;
      end
      StAbort: adv_state = StIdle;
      default: adv_state = state_q;
    endcase
    adv_cmd    = cmd_for(adv_state, adv_idx);
    adv_issues = (adv_state != StIdle) && (adv_state != StPublish);
  end

  assign timeout   = (tcnt_q == TIMEOUT_CYCLES - 1);
  assign nack_fail = (phase_q == PhWait) && done_valid && cmd_q.write && done_nack &&
                     (state_q != StAbort);
  assign fail      = ((phase_q == PhIssue) && !cmd_ready && timeout) ||
                     ((phase_q == PhWait) && !done_valid && timeout) || nack_fail;

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state_q        <= StInitA;
      phase_q        <= PhLoad;
      cmd_q          <= '0;
      cmd_valid_q    <= 1'b0;
      idx_q          <= '0;
      poll_cnt_q     <= '0;
      tcnt_q         <= '0;
      accel_x_q      <= '0;
      accel_y_q      <= '0;
      accel_z_q      <= '0;
      sample_valid_q <= 1'b0;
      init_done_q    <= 1'b0;
      err_cnt_q      <= '0;
      for (int i = 0; i < 6; i++) buf_q[i] <= '0;
    end else begin
      sample_valid_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (poll_cnt_q == POLL_CYCLES - 1) begin
            // Unconfigured device retries INIT regardless of enable; otherwise hold for enable.
            if (!init_done_q || enable) begin
              poll_cnt_q  <= '0;
              state_q     <= init_done_q ? StRdA : StInitA;
              cmd_q       <= cmd_for(init_done_q ? StRdA : StInitA, 3'd0);
              cmd_valid_q <= 1'b1;
              phase_q     <= PhIssue;
              tcnt_q      <= '0;
            end
          end else begin
            poll_cnt_q <= poll_cnt_q + 32'd1;
          end
        end
        StPublish: begin
          accel_x_q      <= {buf_q[1], buf_q[0]};
          accel_y_q      <= {buf_q[3], buf_q[2]};
          accel_z_q      <= {buf_q[5], buf_q[4]};
          sample_valid_q <= 1'b1;
          state_q        <= StIdle;
          poll_cnt_q     <= '0;
        end
        default: begin
          if (phase_q == PhLoad) begin
            cmd_q       <= cmd_for(state_q, idx_q);
            cmd_valid_q <= 1'b1;
            phase_q     <= PhIssue;
            tcnt_q      <= '0;
          end else if (fail) begin
            if (state_q == StAbort) begin
              // A stuck STOP is abandoned silently; the original error is already counted.
              state_q     <= StIdle;
              cmd_q       <= '0;
              cmd_valid_q <= 1'b0;
              poll_cnt_q  <= '0;
            end else begin
              if (err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
              state_q     <= StAbort;
              cmd_q       <= cmd_for(StAbort, 3'd0);
              cmd_valid_q <= 1'b1;
              phase_q     <= PhIssue;
              tcnt_q      <= '0;
            end
          end else if (phase_q == PhIssue) begin
            if (cmd_ready) begin
              cmd_valid_q <= 1'b0;
              phase_q     <= PhWait;
              tcnt_q      <= '0;
            end else begin
              tcnt_q <= tcnt_q + 32'd1;
            end
          end else if (done_valid) begin
            if (state_q == StRdB)   buf_q[idx_q] <= done_rdata;
            if (state_q == StInitD) init_done_q  <= 1'b1;
            state_q <= adv_state;
            idx_q   <= adv_idx;
            tcnt_q  <= '0;
            if (adv_issues) begin
              cmd_q       <= adv_cmd;
              cmd_valid_q <= 1'b1;
              phase_q     <= PhIssue;
            end else begin
              cmd_q       <= '0;
              cmd_valid_q <= 1'b0;
              poll_cnt_q  <= '0;
            end
          end else begin
            tcnt_q <= tcnt_q + 32'd1;
          end
        end
      endcase
    end
  end

  assign cmd_valid    = cmd_valid_q;
  assign cmd_start    = cmd_q.start;
  assign cmd_stop     = cmd_q.stop;
  assign cmd_write    = cmd_q.write;
  assign cmd_read     = cmd_q.read;
  assign cmd_nack     = cmd_q.nack;
  assign cmd_wdata    = cmd_q.wdata;
  assign accel_x      = accel_x_q;
  assign accel_y      = accel_y_q;
  assign accel_z      = accel_z_q;
  assign sample_valid = sample_valid_q;
  assign busy         = (state_q != StIdle);
  assign init_done    = init_done_q;
  assign err_cnt      = err_cnt_q;

endmodule

// File: tb/tb_accel_poll_sequencer.sv
// Directed bench for accel_poll_sequencer: an in-line I2C engine BFM answers each command
// with hand-chosen ACK/NACK and read data; short poll and timeout periods keep runs small.
module tb_accel_poll_sequencer;

  localparam int unsigned Poll = 20;
  localparam int unsigned Tmo  = 16;

  // {start, stop, write, read, nack, wdata}
  localparam logic [12:0] CAddrW  = {5'b10100, 8'h3A};
  localparam logic [12:0] CAddrR  = {5'b10100, 8'h3B};
  localparam logic [12:0] CPwrReg = {5'b00100, 8'h2D};
  localparam logic [12:0] CPwrDat = {5'b01100, 8'h08};
  localparam logic [12:0] CDatReg = {5'b00100, 8'h32};
  localparam logic [12:0] CRdAck  = {5'b00010, 8'h00};
  localparam logic [12:0] CRdLast = {5'b01011, 8'h00};
  localparam logic [12:0] CStop   = {5'b01000, 8'h00};

  logic        clk = 1'b0;
  logic        reset_reset, enable, cmd_ready, done_valid, done_nack;
  logic [7:0]  done_rdata;
  logic        cmd_valid, cmd_start, cmd_stop, cmd_write, cmd_read, cmd_nack;
  logic [7:0]  cmd_wdata, err_cnt;
  logic [15:0] accel_x, accel_y, accel_z;
  logic        sample_valid, busy, init_done;
  logic [12:0] cmd_bits;

  int tests = 0;
  int fails = 0;
  int sv_cnt = 0;
  int n;

  accel_poll_sequencer #(
    .DEV_ADDR(7'h1D),
    .POLL_CYCLES(Poll),
    .TIMEOUT_CYCLES(Tmo)
  ) dut (
    .clk_clk(clk),
    .reset_reset(reset_reset),
    .enable(enable),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_start(cmd_start),
    .cmd_stop(cmd_stop),
    .cmd_write(cmd_write),
    .cmd_read(cmd_read),
    .cmd_nack(cmd_nack),
    .cmd_wdata(cmd_wdata),
    .done_valid(done_valid),
    .done_rdata(done_rdata),
    .done_nack(done_nack),
    .accel_x(accel_x),
    .accel_y(accel_y),
    .accel_z(accel_z),
    .sample_valid(sample_valid),
    .busy(busy),
    .init_done(init_done),
    .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  assign cmd_bits = {cmd_start, cmd_stop, cmd_write, cmd_read, cmd_nack, cmd_wdata};

  always @(posedge clk) if (sample_valid) sv_cnt <= sv_cnt + 1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic count_to_cmd(output int cnt);
    cnt = 0;
    while (!cmd_valid && cnt < 60) begin
      step();
      cnt++;
    end
  endtask

  task automatic finish_cmd(input string tag, input logic nack, input logic [7:0] rdata);
    cmd_ready = 1'b1;
    step();
    cmd_ready = 1'b0;
    check({tag, " drop"}, cmd_valid, 1'b0);
    step();
    done_valid = 1'b1;
    done_nack  = nack;
    done_rdata = rdata;
    step();
    done_valid = 1'b0;
    done_nack  = 1'b0;
    done_rdata = 8'h00;
  endtask

  task automatic do_cmd(input string tag, input logic [12:0] exp, input logic nack,
                        input logic [7:0] rdata);
    int c;
    count_to_cmd(c);
    check({tag, " valid"}, cmd_valid, 1'b1);
    check({tag, " fields"}, cmd_bits, exp);
    finish_cmd(tag, nack, rdata);
  endtask

  initial begin
    reset_reset = 1'b1;
    enable      = 1'b0;
    cmd_ready   = 1'b0;
    done_valid  = 1'b0;
    done_nack   = 1'b0;
    done_rdata  = 8'h00;
    repeat (3) step();
    check("rst cmd_valid", cmd_valid, 1'b0);
    check("rst cmd_bits", cmd_bits, 13'h0);
    check("rst init_done", init_done, 1'b0);
    check("rst err_cnt", err_cnt, 8'h00);
    check("rst accel", {accel_x, accel_y, accel_z}, 48'h0);
    check("rst busy", busy, 1'b1);
    reset_reset = 1'b0;

    // Configuration
    do_cmd("init_a", CAddrW, 1'b0, 8'h00);
    do_cmd("init_r", CPwrReg, 1'b0, 8'h00);
    do_cmd("init_d", CPwrDat, 1'b0, 8'h00);
    check("init done", init_done, 1'b1);
    check("init err", err_cnt, 8'h00);
    check("init idle", busy, 1'b0);

    // First poll lands exactly Poll cycles after entering IDLE
    enable = 1'b1;
    count_to_cmd(n);
    check("poll gap", n, Poll);
    do_cmd("rd_a", CAddrW, 1'b0, 8'h00);
    do_cmd("rd_r", CDatReg, 1'b0, 8'h00);
    do_cmd("rd_a2", CAddrR, 1'b0, 8'h00);
    do_cmd("rd_b0", CRdAck, 1'b0, 8'h10);
    do_cmd("rd_b1", CRdAck, 1'b0, 8'h00);
    do_cmd("rd_b2", CRdAck, 1'b0, 8'hF0);
    do_cmd("rd_b3", CRdAck, 1'b0, 8'hFF);
    do_cmd("rd_b4", CRdAck, 1'b0, 8'h00);
    do_cmd("rd_b5", CRdLast, 1'b0, 8'h01);
    check("pre publish sv", sample_valid, 1'b0);
    step();
    check("publish sv", sample_valid, 1'b1);
    check("accel_x", accel_x, 16'h0010);
    check("accel_y", accel_y, 16'hFFF0);
    check("accel_z", accel_z, 16'h0100);
    step();
    check("sv one cycle", sample_valid, 1'b0);
    count_to_cmd(n);
    check("poll gap 2", n, Poll - 1);

    // Back-pressure with a spurious done during ISSUE
    for (int i = 0; i < 3; i++) begin
      check("stall valid", cmd_valid, 1'b1);
      check("stall fields", cmd_bits, CAddrW);
      done_valid = (i == 1);
      done_nack  = (i == 1);
      step();
    end
    done_valid = 1'b0;
    done_nack  = 1'b0;
    check("stall valid end", cmd_valid, 1'b1);
    check("stall fields end", cmd_bits, CAddrW);
    finish_cmd("stall rd_a", 1'b0, 8'h00);
    check("stall err", err_cnt, 8'h00);

    // NACK on register byte
    do_cmd("nack rd_r", CDatReg, 1'b1, 8'h00);
    check("nack err", err_cnt, 8'h01);
    do_cmd("nack abort", CStop, 1'b0, 8'h00);
    check("nack idle", busy, 1'b0);
    check("nack accel", {accel_x, accel_y, accel_z}, 48'h0010_FFF0_0100);
    check("nack no sample", sv_cnt, 1);
    check("nack init kept", init_done, 1'b1);

    // done withheld -> timeout, then ABORT also times out without a second error
    do_cmd("to rd_a", CAddrW, 1'b0, 8'h00);
    do_cmd("to rd_r", CDatReg, 1'b0, 8'h00);
    do_cmd("to rd_a2", CAddrR, 1'b0, 8'h00);
    count_to_cmd(n);
    check("to rd_b0 fields", cmd_bits, CRdAck);
    cmd_ready = 1'b1;
    step();
    cmd_ready = 1'b0;
    count_to_cmd(n);
    check("to wait cycles", n, Tmo);
    check("to abort fields", cmd_bits, CStop);
    check("to err", err_cnt, 8'h02);
    repeat (Tmo) step();
    check("to abort idle", busy, 1'b0);
    check("to abort valid", cmd_valid, 1'b0);
    check("to err once", err_cnt, 8'h02);

    // Saturation
    for (int i = 0; i < 252; i++) begin
      do_cmd("sat rd_a", CAddrW, 1'b1, 8'h00);
      do_cmd("sat abort", CStop, 1'b0, 8'h00);
    end
    check("sat 254", err_cnt, 8'hFE);
    for (int i = 0; i < 3; i++) begin
      do_cmd("sat rd_a", CAddrW, 1'b1, 8'h00);
      do_cmd("sat abort", CStop, 1'b0, 8'h00);
    end
    check("sat 255", err_cnt, 8'hFF);
    check("sat accel", {accel_x, accel_y, accel_z}, 48'h0010_FFF0_0100);

    // Reset in the middle of the byte reads
    do_cmd("mr rd_a", CAddrW, 1'b0, 8'h00);
    do_cmd("mr rd_r", CDatReg, 1'b0, 8'h00);
    do_cmd("mr rd_a2", CAddrR, 1'b0, 8'h00);
    do_cmd("mr rd_b0", CRdAck, 1'b0, 8'h11);
    do_cmd("mr rd_b1", CRdAck, 1'b0, 8'h22);
    count_to_cmd(n);
    check("mr rd_b2 valid", cmd_valid, 1'b1);
    reset_reset = 1'b1;
    step();
    check("mr cmd_valid", cmd_valid, 1'b0);
    check("mr cmd_bits", cmd_bits, 13'h0);
    check("mr accel", {accel_x, accel_y, accel_z}, 48'h0);
    check("mr init_done", init_done, 1'b0);
    check("mr err", err_cnt, 8'h00);
    check("mr sv", sample_valid, 1'b0);
    check("mr busy", busy, 1'b1);
    reset_reset = 1'b0;
    done_valid  = 1'b1;
    step();
    done_valid  = 1'b0;
    check("mr stale ignored", cmd_bits, CAddrW);
    check("mr stale valid", cmd_valid, 1'b1);

    // Failed INIT retries after Poll cycles even with enable low
    enable = 1'b0;
    do_cmd("fi init_a", CAddrW, 1'b1, 8'h00);
    do_cmd("fi abort", CStop, 1'b0, 8'h00);
    check("fi init_done", init_done, 1'b0);
    check("fi err", err_cnt, 8'h01);
    count_to_cmd(n);
    check("fi retry gap", n, Poll);
    check("fi retry fields", cmd_bits, CAddrW);
    finish_cmd("fi init_a", 1'b0, 8'h00);
    do_cmd("fi init_r", CPwrReg, 1'b0, 8'h00);
    do_cmd("fi init_d", CPwrDat, 1'b0, 8'h00);
    check("fi init ok", init_done, 1'b1);
    check("fi sample count", sv_cnt, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/accel_poll_sequencer.md
Name: accel_poll_sequencer

Overview:
- Hardware sequencer that drives a byte-level I2C command engine to configure the ADXL345 accelerometer once, then poll its six data registers periodically.
- Publishes signed X/Y/Z samples to the display/PIO logic.
- Sits between the I2C master core and the 7-segment formatting logic, replacing software polling by the Nios.
- Only one I2C command is ever outstanding.

Parameters:
- DEV_ADDR, 7'h1D, 7-bit I2C slave address.
- POLL_CYCLES, 5000000, IDLE cycles between polls (100 ms at 50 MHz); must be >= 2.
- TIMEOUT_CYCLES, 100000, maximum cycles spent waiting for cmd_ready or done_valid on any one command.

Ports:
- clk_clk  in  1  system clock
- reset_reset  in  1  synchronous active-high reset
- enable  in  1  polling permitted; sampled only in IDLE
- cmd_valid  out  1  command offered to I2C engine
- cmd_ready  in  1  engine accepts command this cycle
- cmd_start  out  1  generate (repeated) START before byte
- cmd_stop  out  1  generate STOP after byte (or STOP only if no read/write)
- cmd_write  out  1  transmit cmd_wdata
- cmd_read  out  1  receive one byte
- cmd_nack  out  1  master NACKs the read byte (last byte)
- cmd_wdata  out  8  byte to transmit
- done_valid  in  1  one-cycle pulse: accepted command finished
- done_rdata  in  8  received byte, valid with done_valid
- done_nack  in  1  slave NACKed written byte, valid with done_valid
- accel_x, accel_y, accel_z  out  16 each  signed samples, two's complement
- sample_valid  out  1  one-cycle pulse when X/Y/Z update
- busy  out  1  high in every state except IDLE
- init_done  out  1  configuration write succeeded
- err_cnt  out  8  saturating error count

Behaviour:
- Reset, synchronous and active-high, is decided. Reset forces state INIT_A and clears:
  - all cmd_* outputs, accel_x/y/z, sample_valid, init_done, err_cnt, the byte index and both counters.
  - Reset mid-transaction simply abandons the bus. Stale done_valid pulses after reset are ignored because no command is outstanding.
- Command handshake:
  - In an ISSUE phase, cmd_valid=1 with all fields stable until a cycle where cmd_ready=1. That cycle transfers the command; cmd_valid drops the next cycle.
  - The WAIT phase then waits for done_valid. A done_valid seen during ISSUE is ignored.
  - The timeout counter clears on entry to each ISSUE and each WAIT. Reaching TIMEOUT_CYCLES-1 gives err and goes to ABORT.
- States and commands, in sequence ({start,stop,write,read,nack}, wdata):
  - INIT_A: S,W, (DEV_ADDR<<1)|0
  - INIT_R: W, 0x2D
  - INIT_D: W,P, 0x08. On done it sets init_done=1, then goes to IDLE.
  - IDLE: poll counter increments each cycle. When the counter reaches POLL_CYCLES-1, it clears and:
    - init_done=0 goes to INIT_A, regardless of enable.
    - otherwise enable=1 goes to RD_A.
    - otherwise the counter holds at POLL_CYCLES-1 until enable.
  - RD_A: S,W, (DEV_ADDR<<1)|0
  - RD_R: W, 0x32
  - RD_A2: S,W, (DEV_ADDR<<1)|1
  - RD_B, index i=0..5:
    - read with ACK for i<5; read with NACK and STOP for i=5.
    - done_rdata goes into buffer byte i.
  - PUBLISH, one cycle, then IDLE:
    - accel_x={b1,b0}, accel_y={b3,b2}, accel_z={b5,b4}, all updated in the same cycle.
    - sample_valid=1 for exactly that cycle.
- Error handling:
  - done_nack=1 on any write command goes to ABORT with err.
  - done_nack is ignored on read commands.
- ABORT:
  - Issues a STOP-only command (cmd_stop=1, start/write/read=0), with its own timeout.
  - Goes to IDLE on done or on timeout; the ABORT timeout does not add a second err.
  - init_done is unchanged if already 1, so a failed read leaves it set.
  - A failed INIT leaves init_done=0, so INIT retries after POLL_CYCLES.
- err: err_cnt increments by 1 and saturates at 255. accel_x/y/z keep their previous values on any abort.
- busy = (state != IDLE).

Test Plan:
- Reset, then the BFM ACKs everything -> exact command sequence INIT_A/R/D: (S,W,0x3A), (W,0x2D), (W,P,0x08); init_done=1; err_cnt=0.
- enable=1, BFM returns bytes 0x10,0x00,0xF0,0xFF,0x00,0x01 -> RD commands addr 0x3A, reg 0x32, S addr 0x3B, five ACK reads then NACK+P read; accel_x=0x0010, accel_y=0xFFF0 (-16), accel_z=0x0100; one sample_valid pulse; next RD_A issued POLL_CYCLES cycles after return to IDLE.
- cmd_ready held low 3 cycles -> cmd_valid and all fields stay stable; a spurious done_valid during ISSUE is ignored; the command transfers on the first ready cycle.
- BFM NACKs the 0x32 register byte -> STOP-only command issued; err_cnt=1; accel_x/y/z unchanged; no sample_valid pulse.
- BFM NACKs the address during INIT -> init_done stays 0; INIT_A re-issued after POLL_CYCLES even with enable=0.
- done_valid withheld for TIMEOUT_CYCLES -> ABORT entered; err_cnt increments once.
- Repeated errors -> err_cnt saturates at 255.
- reset_reset asserted mid RD_B -> next cycle cmd_valid=0, state INIT_A, all outputs 0.
